// File: rtl/boxhead_pkg.sv
// +--------------------------------------------------------------------+
// | boxhead_pkg : shared types, game constants and per-axis step helper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package boxhead_pkg;

  typedef logic [8:0] coord_t;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_DEAD  = 2'd1,
    ST_SPAWN = 2'd2
  } enemy_state_t;

  localparam int     ENEMY_NUM    = 4;
  localparam int     RESPAWN_TIME = 80;
  localparam coord_t X_MAX_DEF    = 9'd454;
  localparam coord_t Y_MAX_DEF    = 9'd454;

  // Widened signed arithmetic keeps the step from wrapping past 0 or 511.
  function automatic coord_t step_axis(coord_t pos, coord_t tgt, coord_t step, coord_t lim);
    logic signed [9:0]  d;
    logic signed [9:0]  mag;
    logic signed [10:0] r;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    mag = d[9] ? -d : d;
    if (mag <= $signed({1'b0, step}))
      r = $signed({2'b00, tgt});
    else if (d[9])
      r = $signed({2'b00, pos}) - $signed({2'b00, step});
    else
      r = $signed({2'b00, pos}) + $signed({2'b00, step});
    if (r[10])
      r = '0;
    else if (r > $signed({2'b00, lim}))
      r = $signed({2'b00, lim});
    return r[8:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_controller_frame_tick.sv
// +--------------------------------------------------------------------+
// | frame_tick : frame_clk edge detector and move-tick divider          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module frame_tick #(
  parameter int MOVE_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_frame_clk,
  output logic o_tick,
  output logic o_move
);

  localparam int               c_cnt_w = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MOVE_DIV - 1);

  logic               r_fc;
  logic               r_fc_d;
  logic               r_tick;
  logic [c_cnt_w-1:0] r_div;
  logic               w_wrap;

  assign w_wrap = (r_div == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fc   <= 1'b0;
      r_fc_d <= 1'b0;
      r_tick <= 1'b0;
      r_div  <= '0;
    end else begin
      r_fc   <= i_frame_clk;
      r_fc_d <= r_fc;
      r_tick <= r_fc & ~r_fc_d;
      if (r_tick)
        r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end

  assign o_tick = r_tick;
  assign o_move = r_tick & w_wrap;

endmodule

`default_nettype wire

// File: rtl/enemy_controller.sv
// +--------------------------------------------------------------------+
// | enemy_controller : per-enemy chase movement and corner respawn      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module enemy_controller
  import boxhead_pkg::*;
#(
  parameter int     RESPAWN_FRAMES = RESPAWN_TIME,
  parameter coord_t STEP           = 9'd1,
  parameter int     MOVE_DIV       = 2,
  parameter coord_t X_MAX          = X_MAX_DEF,
  parameter coord_t Y_MAX          = Y_MAX_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Enemy_Alive,
  output logic [8:0] Enemy_X,
  output logic [8:0] Enemy_Y,
  output logic       Enemy_Visible,
  output logic       Respawn
);

  localparam int               c_frm_w = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [c_frm_w-1:0] c_frm_last = c_frm_w'(RESPAWN_FRAMES - 1);

  enemy_state_t       r_state;
  enemy_state_t       w_next;
  coord_t             r_x;
  coord_t             r_y;
  logic [1:0]         r_corner;
  logic [c_frm_w-1:0] r_frames;
  logic               w_tick;
  logic               w_move;
  logic               w_last_frame;

  frame_tick #(
    .MOVE_DIV (MOVE_DIV)
  ) u_frame_tick (
    .clk         (Clk),
    .rst         (Reset),
    .i_frame_clk (frame_clk),
    .o_tick      (w_tick),
    .o_move      (w_move)
  );

  assign w_last_frame = (r_frames == c_frm_last);

  always_ff @(posedge Clk) begin
    if (Reset)
      r_state <= ST_ALIVE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ALIVE: if (!Enemy_Alive)            w_next = ST_DEAD;
      ST_DEAD:  if (w_tick && w_last_frame)  w_next = ST_SPAWN;
      ST_SPAWN: if (Enemy_Alive)             w_next = ST_ALIVE;
      default:                               w_next = ST_ALIVE;
    endcase
  end

  always_comb begin
    Enemy_Visible = 1'b0;
    Respawn       = 1'b0;
    case (r_state)
      ST_ALIVE: Enemy_Visible = 1'b1;
      ST_SPAWN: Respawn       = 1'b1;
      default:  ;
    endcase
  end

  // Death check outranks a coincident move, so the position freezes on death.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_corner <= 2'd1;
      r_frames <= '0;
    end else begin
      case (r_state)
        ST_ALIVE: begin
          if (!Enemy_Alive)
            r_frames <= '0;
          else if (w_move) begin
            r_x <= step_axis(r_x, Player_X, STEP, X_MAX);
            r_y <= step_axis(r_y, Player_Y, STEP, Y_MAX);
          end
        end
        ST_DEAD: begin
          if (w_tick) begin
            if (w_last_frame) begin
              r_x      <= r_corner[0] ? X_MAX : 9'd0;
              r_y      <= r_corner[1] ? Y_MAX : 9'd0;
              r_corner <= r_corner + 1'b1;
            end else begin
              r_frames <= r_frames + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Enemy_X = r_x;
  assign Enemy_Y = r_y;

endmodule

`default_nettype wire
